// File: rtl/tx_align_pattern_gen.sv
// Transmit-side link trainer: sends idle/training words into the OSERDES until the far end
// reports bit alignment, then passes user data. Define TX_PRBS_EN for PRBS7 training words.
module tx_align_pattern_gen #(
  parameter logic [7:0] IDLE_WORD   = 8'h3C,
  parameter logic [7:0] TRAIN_WORD  = 8'hB4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk160,
  input  logic        rstb,
  input  logic        train_start,
  input  logic [15:0] train_len,
  input  logic [15:0] lock_timeout,
  input  logic        rx_aligned,
  input  logic        clear_err,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  D_OUT,
  output logic        link_up,
  output logic        train_busy,
  output logic        timeout_err,
  output logic [3:0]  retry_cnt,
  output logic [15:0] words_sent
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRAIN     = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_LINK      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            tmr_q, tmr_d;
  logic [7:0]             d_out_q, d_out_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [3:0]             retry_q, retry_d;
  logic [15:0]            words_q, words_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   enter_train;
  logic                   timeout_hit;
  logic [3:0]             retry_base;
  logic [7:0]             train_word;

  // rx_aligned comes from the far end's clock domain; first flop may go metastable.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_aligned};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

`ifdef TX_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] lfsr_adv;
  logic       fb_bit;

  // Eight serial PRBS7 steps per word; the first generated bit lands in bit 7.
  always_comb begin
    lfsr_adv   = lfsr_q;
    train_word = '0;
    fb_bit     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb_bit            = lfsr_adv[6] ^ lfsr_adv[5];
      train_word[7 - i] = fb_bit;
      lfsr_adv          = {lfsr_adv[5:0], fb_bit};
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (enter_train) begin
      lfsr_d = 7'h7F;
    end else if (state_q == ST_TRAIN || state_q == ST_WAIT_LOCK) begin
      lfsr_d = lfsr_adv;
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign train_word = TRAIN_WORD;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    d_out_d     = IDLE_WORD;
    words_d     = words_q;
    enter_train = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (train_start) begin
          enter_train = 1'b1;
        end
      end
      ST_TRAIN: begin
        d_out_d = train_word;
        if (train_start) begin
          enter_train = 1'b1;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = lock_timeout;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_WAIT_LOCK: begin
        d_out_d = train_word;
        if (train_start) begin
          enter_train = 1'b1;
        end else if (rx_sync) begin
          state_d = ST_LINK;
        end else if (tmr_q == 16'd0) begin
          timeout_hit = 1'b1;
          enter_train = 1'b1;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      ST_LINK: begin
        // The word offered in the last LINK cycle is still accepted even if we leave.
        if (tx_valid) begin
          d_out_d = tx_data;
          if (words_q != 16'hFFFF) begin
            words_d = words_q + 16'd1;
          end
        end
        if (train_start || !rx_sync) begin
          enter_train = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_train) begin
      state_d = ST_TRAIN;
      cnt_d   = train_len;
      words_d = '0;
    end
  end

  // A timeout in the same cycle as clear_err wins over the clear.
  always_comb begin
    retry_base    = clear_err ? 4'd0 : retry_q;
    retry_d       = retry_base;
    timeout_err_d = clear_err ? 1'b0 : timeout_err_q;
    if (timeout_hit) begin
      timeout_err_d = 1'b1;
      retry_d       = (retry_base == 4'hF) ? 4'hF : retry_base + 4'd1;
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      d_out_q       <= IDLE_WORD;
      timeout_err_q <= 1'b0;
      retry_q       <= '0;
      words_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      d_out_q       <= d_out_d;
      timeout_err_q <= timeout_err_d;
      retry_q       <= retry_d;
      words_q       <= words_d;
    end
  end

  assign D_OUT       = d_out_q;
  assign link_up     = (state_q == ST_LINK);
  assign tx_ready    = (state_q == ST_LINK);
  assign train_busy  = (state_q == ST_TRAIN) || (state_q == ST_WAIT_LOCK);
  assign timeout_err = timeout_err_q;
  assign retry_cnt   = retry_q;
  assign words_sent  = words_q;

endmodule
